wb_regfile: RTL and testbench

//  Writeback-end consumer of the MEM/WB pipeline register: selects the final result,

---
 rtl/wb_regfile_pkg.sv | 10 +
 rtl/wb_result_mux.sv | 18 +
 rtl/wb_regfile.sv | 60 ++++++
 tb/tb_wb_regfile.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/wb_regfile_pkg.sv
// wb_regfile_pkg: shared result-select codes and register file geometry
package wb_regfile_pkg;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int REG_AW = 5;
  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;
  localparam logic [1:0] RES_IMM = 2'b11;
endpackage

// File: rtl/wb_result_mux.sv
// wb_result_mux: 4:1 writeback result select
module wb_result_mux
  import wb_regfile_pkg::*;
#(
  parameter int XLEN = wb_regfile_pkg::XLEN
) (
  input  logic [1:0]      i_src,
  input  logic [XLEN-1:0] i_alu,
  input  logic [XLEN-1:0] i_mem,
  input  logic [XLEN-1:0] i_pc4,
  input  logic [XLEN-1:0] i_imm,
  output logic [XLEN-1:0] o_result
);
  always_comb
    o_result = i_src == RES_ALU ? i_alu :
               i_src == RES_MEM ? i_mem :
               i_src == RES_PC4 ? i_pc4 : i_imm;
endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: writeback result select, register file with write-through bypass,
// and a retired-instruction counter
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int XLEN  = wb_regfile_pkg::XLEN,
  parameter int NREG  = wb_regfile_pkg::NREG,
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              validW,
  input  logic              regWriteW,
  input  logic [1:0]        resultSrcW,
  input  logic [REG_AW-1:0] RdW,
  input  logic [XLEN-1:0]   ALUResultW,
  input  logic [XLEN-1:0]   RDW,
  input  logic [XLEN-1:0]   PCPlus4W,
  input  logic [XLEN-1:0]   extImmW,
  input  logic [REG_AW-1:0] A1D,
  input  logic [REG_AW-1:0] A2D,
  output logic [XLEN-1:0]   RD1D,
  output logic [XLEN-1:0]   RD2D,
  output logic [XLEN-1:0]   resultW,
  output logic [CNT_W-1:0]  retiredW
);
  logic [XLEN-1:0]  r_regs [1:NREG-1];
  logic [CNT_W-1:0] r_retired;
  logic             w_commit;
  logic             w_we;

  wb_result_mux #(.XLEN(XLEN)) u_mux (
    .i_src    (resultSrcW),
    .i_alu    (ALUResultW),
    .i_mem    (RDW),
    .i_pc4    (PCPlus4W),
    .i_imm    (extImmW),
    .o_result (resultW)
  );

  // A live write that is out of reset; flushed bubbles never write or bypass
  assign w_commit = regWriteW && validW && rst;
  assign w_we     = w_commit && RdW != '0;

  always_ff @(posedge clk)
    if (!rst) begin
      for (int i = 1; i < NREG; i++) r_regs[i] <= '0;
      r_retired <= '0;
    end else begin
      if (w_we) r_regs[RdW] <= resultW;
      if (validW) r_retired <= r_retired + CNT_W'(1);
    end

  always_comb begin
    RD1D = A1D == '0 ? '0 : (w_commit && RdW == A1D) ? resultW : r_regs[A1D];
    RD2D = A2D == '0 ? '0 : (w_commit && RdW == A2D) ? resultW : r_regs[A2D];
  end

  assign retiredW = r_retired;
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed checks of result select, bypass, x0, bubbles, reset and counter wrap
module tb_wb_regfile;
  logic        clk = 0;
  logic        rst;
  logic        validW, regWriteW;
  logic [1:0]  resultSrcW;
  logic [4:0]  RdW, A1D, A2D;
  logic [31:0] ALUResultW, RDW, PCPlus4W, extImmW;
  logic [31:0] RD1D, RD2D, resultW, retiredW;
  logic [31:0] RD1D4, RD2D4, resultW4;
  logic [3:0]  retiredW4;
  int n_pass = 0, n_total = 0;

  always #5 clk = ~clk;

  wb_regfile dut (
    .clk(clk), .rst(rst), .validW(validW), .regWriteW(regWriteW), .resultSrcW(resultSrcW),
    .RdW(RdW), .ALUResultW(ALUResultW), .RDW(RDW), .PCPlus4W(PCPlus4W), .extImmW(extImmW),
    .A1D(A1D), .A2D(A2D), .RD1D(RD1D), .RD2D(RD2D), .resultW(resultW), .retiredW(retiredW)
  );

  wb_regfile #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .validW(validW), .regWriteW(regWriteW), .resultSrcW(resultSrcW),
    .RdW(RdW), .ALUResultW(ALUResultW), .RDW(RDW), .PCPlus4W(PCPlus4W), .extImmW(extImmW),
    .A1D(A1D), .A2D(A2D), .RD1D(RD1D4), .RD2D(RD2D4), .resultW(resultW4), .retiredW(retiredW4)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 0; validW = 1; regWriteW = 1; RdW = 4; resultSrcW = 2'b00; ALUResultW = 32'h1111;
    tick; tick;
    rst = 1; validW = 0; regWriteW = 0;
    for (int i = 1; i < 32; i++) begin
      A1D = 5'(i); A2D = 5'(i); #1;
      n_total++;
      if (RD1D !== 0 || RD2D !== 0) $display("FAIL reset_x%0d rd1=%h rd2=%h want 0", i, RD1D, RD2D);
      else n_pass++;
    end
    n_total++;
    if (retiredW !== 0 || retiredW4 !== 0) $display("FAIL reset_retired got %0d/%0d want 0", retiredW, retiredW4);
    else n_pass++;
  endtask

  task automatic test_write_read;
    validW = 1; regWriteW = 1; RdW = 5; resultSrcW = 2'b00; ALUResultW = 32'hDEADBEEF; A1D = 0; A2D = 0;
    tick;
    validW = 0; regWriteW = 0; A1D = 5; #1;
    n_total++;
    if (RD1D !== 32'hDEADBEEF) $display("FAIL write_read got %h want deadbeef", RD1D);
    else n_pass++;
    n_total++;
    if (retiredW !== 1) $display("FAIL write_read_retired got %0d want 1", retiredW);
    else n_pass++;
  endtask

  task automatic test_bypass;
    validW = 1; regWriteW = 1; RdW = 7; resultSrcW = 2'b01; RDW = 32'h12345678;
    PCPlus4W = 32'h00000104; extImmW = 32'hABCDE000; A1D = 7; A2D = 7; #1;
    n_total++;
    if (RD1D !== 32'h12345678 || RD2D !== 32'h12345678) $display("FAIL bypass_mem rd1=%h rd2=%h want 12345678", RD1D, RD2D);
    else n_pass++;
    resultSrcW = 2'b10; #1;
    n_total++;
    if (RD1D !== 32'h104 || resultW !== 32'h104) $display("FAIL bypass_pc4 rd1=%h res=%h want 00000104", RD1D, resultW);
    else n_pass++;
    resultSrcW = 2'b11; #1;
    n_total++;
    if (RD2D !== 32'hABCDE000 || resultW !== 32'hABCDE000) $display("FAIL bypass_imm rd2=%h res=%h want abcde000", RD2D, resultW);
    else n_pass++;
    tick;
    validW = 0; regWriteW = 0; resultSrcW = 2'b00; #1;
    n_total++;
    if (RD1D !== 32'hABCDE000 || retiredW !== 2) $display("FAIL bypass_commit rd1=%h ret=%0d want abcde000/2", RD1D, retiredW);
    else n_pass++;
  endtask

  task automatic test_x0;
    validW = 1; regWriteW = 1; RdW = 0; resultSrcW = 2'b00; ALUResultW = 32'hFFFFFFFF; A1D = 0; A2D = 0; #1;
    n_total++;
    if (RD1D !== 0 || RD2D !== 0 || resultW !== 32'hFFFFFFFF) $display("FAIL x0_bypass rd1=%h rd2=%h res=%h want 0/0/ffffffff", RD1D, RD2D, resultW);
    else n_pass++;
    tick;
    validW = 0; regWriteW = 0; #1;
    n_total++;
    if (RD1D !== 0 || retiredW !== 3) $display("FAIL x0_commit rd1=%h ret=%0d want 0/3", RD1D, retiredW);
    else n_pass++;
  endtask

  task automatic test_bubble_reset;
    validW = 0; regWriteW = 1; RdW = 3; resultSrcW = 2'b00; ALUResultW = 32'h33; A1D = 3; #1;
    n_total++;
    if (RD1D !== 0) $display("FAIL bubble_bypass got %h want 0", RD1D);
    else n_pass++;
    tick;
    n_total++;
    if (RD1D !== 0 || retiredW !== 3) $display("FAIL bubble_commit rd1=%h ret=%0d want 0/3", RD1D, retiredW);
    else n_pass++;
    validW = 1; RdW = 4; ALUResultW = 32'h44;
    tick;
    rst = 0; validW = 1; regWriteW = 1; RdW = 4; ALUResultW = 32'h55; A1D = 4; A2D = 5; #1;
    n_total++;
    if (RD1D !== 32'h44) $display("FAIL reset_no_bypass got %h want 00000044", RD1D);
    else n_pass++;
    tick;
    rst = 1; validW = 0; regWriteW = 0; #1;
    n_total++;
    if (RD1D !== 0 || RD2D !== 0 || retiredW !== 0) $display("FAIL reset_collision x4=%h x5=%h ret=%0d want 0/0/0", RD1D, RD2D, retiredW);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    validW = 1; regWriteW = 1; resultSrcW = 2'b00;
    RdW = 10; ALUResultW = 32'hA0A0; tick;
    RdW = 11; ALUResultW = 32'hB1B1; A1D = 10; A2D = 11; #1;
    n_total++;
    if (RD1D !== 32'hA0A0 || RD2D !== 32'hB1B1) $display("FAIL b2b_mix rd1=%h rd2=%h want a0a0/b1b1", RD1D, RD2D);
    else n_pass++;
    tick;
    RdW = 12; ALUResultW = 32'hC2C2; A1D = 12; A2D = 11; #1;
    n_total++;
    if (RD1D !== 32'hC2C2 || RD2D !== 32'hB1B1) $display("FAIL b2b_next rd1=%h rd2=%h want c2c2/b1b1", RD1D, RD2D);
    else n_pass++;
    tick;
    validW = 0; regWriteW = 0; #1;
    n_total++;
    if (retiredW !== 3) $display("FAIL b2b_retired got %0d want 3", retiredW);
    else n_pass++;
  endtask

  task automatic test_wrap;
    rst = 0; tick; rst = 1;
    validW = 1; regWriteW = 0;
    for (int i = 0; i < 17; i++) tick;
    validW = 0; #1;
    n_total++;
    if (retiredW4 !== 4'd1) $display("FAIL wrap_cnt4 got %0d want 1", retiredW4);
    else n_pass++;
    n_total++;
    if (retiredW !== 17) $display("FAIL wrap_cnt32 got %0d want 17", retiredW);
    else n_pass++;
  endtask

  initial begin
    rst = 0; validW = 0; regWriteW = 0; resultSrcW = 0; RdW = 0; A1D = 0; A2D = 0;
    ALUResultW = 0; RDW = 0; PCPlus4W = 0; extImmW = 0;
    test_reset;
    test_write_read;
    test_bypass;
    test_x0;
    test_bubble_reset;
    test_back_to_back;
    test_wrap;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
